rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter sharing one downstream resource among requesters `req[7:0]`, with a bounded hold time. It produces a one-hot grant plus its binary index, so the resource mux can select directly by index. The block sits between the requester bank and the shared resource's select logic, and it is the sequencing front end for the encoder datapath.

---
 rtl/rr_arbiter8.sv | 152 +++++++++++++++
 tb/tb_rr_arbiter8.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with bounded hold time
//
// Shares one downstream resource among eight level-sensitive requesters.
// An owner keeps the grant until it drops its request, or until it has held
// the grant for HOLD_MAX cycles while someone else is waiting.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req[7:0]     request vector, bit i belongs to requester i
//   grant[7:0]   registered one-hot grant, zero when idle
//   grant_idx    registered binary index of the granted bit, zero when idle
//   grant_valid  registered, equals |grant
//   preempt      one-cycle pulse on the first cycle of a grant that
//                followed a timeout release
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } st_t;

    // Counter value at which the current owner has been visible for
    // HOLD_MAX cycles; the counter starts at 0 on the first grant cycle.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    st_t        st_q, st_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] last_q, last_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       preempt_q, preempt_d;

    logic [7:0] others;

    // First set bit of vec searching from+1, from+2, ... wrapping, ending at
    // from itself. Returns from when vec is empty; callers only use the
    // result when vec is non-zero.
    function automatic logic [2:0] pick(input logic [7:0] vec,
                                        input logic [2:0] from);
        logic [2:0] res;
        logic [2:0] idx;
        logic       found;
        res   = from;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = from + 3'(k);
            if (!found && vec[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Requests from everyone except the current owner.
    assign others = req & ~(8'b1 << owner_q);

    always_comb begin
        st_d       = st_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        case (st_q)
            IDLE: begin
                if (req != 8'h00) begin
                    owner_d    = pick(req, last_q);
                    st_d       = BUSY;
                    hold_cnt_d = 8'h00;
                end
            end
            BUSY: begin
                if (!req[owner_q]) begin
                    // Release has priority over timeout, so no preempt here.
                    last_d     = owner_q;
                    hold_cnt_d = 8'h00;
                    if (req != 8'h00) begin
                        owner_d = pick(req, owner_q);
                    end else begin
                        st_d = IDLE;
                    end
                end else if (hold_cnt_q == HOLD_LAST && others != 8'h00) begin
                    last_d     = owner_q;
                    owner_d    = pick(others, owner_q);
                    hold_cnt_d = 8'h00;
                    preempt_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    // Saturating: an uncontested owner holds indefinitely,
                    // and a newcomer then triggers the timeout on the next edge.
                    hold_cnt_d = hold_cnt_q + 8'h01;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register together.
        if (st_d == BUSY) begin
            grant_d       = 8'b1 << owner_d;
            grant_idx_d   = owner_d;
            grant_valid_d = 1'b1;
        end else begin
            grant_d       = 8'h00;
            grant_idx_d   = 3'd0;
            grant_valid_d = 1'b0;
            preempt_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q          <= IDLE;
            owner_q       <= 3'd0;
            last_q        <= 3'd7;
            hold_cnt_q    <= 8'h00;
            grant_q       <= 8'h00;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
        end else begin
            st_q          <= st_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            preempt_q     <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    int total;
    int bad;

    // Reference model: who holds the resource and for how many visible cycles.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;
    bit m_pre;

    rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .preempt    (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mpick(input logic [7:0] v, input int from);
        for (int k = 1; k <= 8; k++) begin
            if (v[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rn, input logic [7:0] r);
        logic [7:0] oth;
        if (!rn) begin
            m_busy = 0; m_owner = 0; m_last = 7; m_held = 0; m_pre = 0;
            return;
        end
        m_pre = 0;
        if (!m_busy) begin
            if (r != 0) begin
                m_owner = mpick(r, m_last); m_busy = 1; m_held = 1;
            end
        end else if (!r[m_owner]) begin
            m_last = m_owner;
            if (r != 0) begin
                m_owner = mpick(r, m_owner); m_held = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (m_held >= HOLD && oth != 0) begin
                m_last = m_owner; m_owner = mpick(oth, m_owner); m_held = 1; m_pre = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst_n, req);
        #1;
        chk("grant", 32'(grant), m_busy ? 32'(1 << m_owner) : 32'd0);
        chk("grant_idx", 32'(grant_idx), m_busy ? 32'(m_owner) : 32'd0);
        chk("grant_valid", 32'(grant_valid), 32'(m_busy));
        chk("preempt", 32'(preempt), 32'(m_pre));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 8'hFF;
        m_busy = 0; m_owner = 0; m_last = 7; m_held = 0; m_pre = 0;

        // Reset with all requests pending.
        repeat (2) begin
            tick();
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_valid", 32'(grant_valid), 32'h0);
        end
        rst_n = 1'b1;

        // Full rotation under saturation: each index held HOLD cycles.
        for (int c = 0; c < 36; c++) begin
            tick();
            chk("rot_idx", 32'(grant_idx), 32'((c / HOLD) % 8));
            chk("rot_pre", 32'(preempt), 32'((c > 0) && (c % HOLD == 0)));
        end

        // Owner 2 releases while 5 waits: back-to-back handoff.
        rst_n = 1'b0; req = 8'h00; tick();
        rst_n = 1'b1; req = 8'h24; tick();
        chk("own2_idx", 32'(grant_idx), 32'd2);
        req = 8'h20; tick();
        chk("hand_grant", 32'(grant), 32'h20);
        chk("hand_pre", 32'(preempt), 32'd0);
        chk("hand_valid", 32'(grant_valid), 32'd1);

        // Lone requester holds indefinitely without preempt.
        req = 8'h08;
        repeat (40) begin
            tick();
            chk("lone_grant", 32'(grant), 32'h08);
            chk("lone_pre", 32'(preempt), 32'd0);
        end

        // Owner 6 releases, idle gap, then search wraps from 6 to 0.
        req = 8'h40; tick();
        chk("own6", 32'(grant), 32'h40);
        req = 8'h00;
        repeat (3) begin
            tick();
            chk("idle_grant", 32'(grant), 32'h0);
        end
        req = 8'h41; tick();
        chk("wrap_idx", 32'(grant_idx), 32'd0);

        // Reset mid-grant restarts the search pointer at 7.
        req = 8'h10; tick();
        chk("pre_rst_grant", 32'(grant), 32'h10);
        rst_n = 1'b0; req = 8'h30; tick();
        chk("mid_rst_grant", 32'(grant), 32'h0);
        rst_n = 1'b1; tick();
        chk("post_rst_idx", 32'(grant_idx), 32'd4);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] r;
            r = req;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            if (m_busy && $urandom_range(0, 14) == 0) r[m_owner] = 1'b0;
            if ($urandom_range(0, 99) == 0) r = 8'hFF;
            if ($urandom_range(0, 99) == 0) r = 8'h00;
            req   = r;
            rst_n = ($urandom_range(0, 249) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
